// File: rtl/pipelined_mem_stage_if.sv
// pipelined_mem_stage_if: EX/MEM-to-WB bus; wb_misalign exists only with MEM_MISALIGN_TRAP_EN
interface pipelined_mem_stage_if #(parameter int REG_W = 5);
  logic [1:0] mem_wb;
  logic mem_branch;
  logic mem_zero;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic mem_write;
  logic mem_read;
  logic [1:0] mem_size;
  logic mem_unsigned;
  logic [REG_W-1:0] write_reg;
  logic mem_pcsrc;
  logic mem_stall;
  logic [1:0] wb_control;
  logic [31:0] wb_read_data;
  logic [31:0] wb_alu_result;
  logic [REG_W-1:0] wb_write_reg;
`ifdef MEM_MISALIGN_TRAP_EN
  logic wb_misalign;
`endif
  modport master (
`ifdef MEM_MISALIGN_TRAP_EN
    input wb_misalign,
`endif
    output mem_wb, mem_branch, mem_zero, mem_address, mem_write_data, mem_write, mem_read,
    output mem_size, mem_unsigned, write_reg,
    input mem_pcsrc, mem_stall, wb_control, wb_read_data, wb_alu_result, wb_write_reg
  );
  modport slave (
`ifdef MEM_MISALIGN_TRAP_EN
    output wb_misalign,
`endif
    input mem_wb, mem_branch, mem_zero, mem_address, mem_write_data, mem_write, mem_read,
    input mem_size, mem_unsigned, write_reg,
    output mem_pcsrc, mem_stall, wb_control, wb_read_data, wb_alu_result, wb_write_reg
  );
endinterface

// File: rtl/pipelined_mem_stage.sv
// pipelined_mem_stage: MEM stage with byte-lane data memory, wait states and MEM/WB register; MEM_MISALIGN_TRAP_EN enables misalignment trapping
module pipelined_mem_stage #(
  parameter int DEPTH = 256,
  parameter int WAIT_CYCLES = 0,
  parameter int REG_W = 5
) (
  input logic clk,
  input logic reset,
  pipelined_mem_stage_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic [1:0] lane;
  logic [3:0] be;
  logic req, mis, half, word, stall, commit, sx;
  logic [31:0] wdata, rword, rshift, rdata;
  logic [REG_W-1:0] wreg;
  assign half = bus.mem_size == 2'b01;
  assign word = bus.mem_size[1];
  assign req = bus.mem_read | bus.mem_write;
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = req && (half ? bus.mem_address[0] : word && bus.mem_address[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign idx = bus.mem_address[AW+1:2];
  // misaligned low bits are dropped: half uses lane 0/2, word uses lane 0
  assign lane = word ? 2'b00 : half ? {bus.mem_address[1], 1'b0} : bus.mem_address[1:0];
  assign be = word ? 4'hF : half ? 4'b0011 << lane : 4'b0001 << lane;
  assign wdata = word ? bus.mem_write_data : half ? {2{bus.mem_write_data[15:0]}} : {4{bus.mem_write_data[7:0]}};
  assign stall = WAIT_CYCLES != 0 && (state == IDLE ? req && !mis : cnt != 4'd0);
  assign commit = bus.mem_write && !mis && !stall && !reset;
  assign rword = mem[idx];
  assign rshift = rword >> {lane, 3'b000};
  assign sx = !bus.mem_unsigned && (half ? rshift[15] : rshift[7]);
  assign rdata = (!bus.mem_read || bus.mem_write || mis) ? 32'd0 :
                 word ? rword : half ? {{16{sx}}, rshift[15:0]} : {{24{sx}}, rshift[7:0]};
  assign wreg = bus.write_reg;
  assign bus.mem_stall = stall;
  assign bus.mem_pcsrc = bus.mem_branch & bus.mem_zero;
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (commit && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      bus.wb_control <= 2'b00;
      bus.wb_read_data <= 32'd0;
      bus.wb_alu_result <= 32'd0;
      bus.wb_write_reg <= '0;
    end else begin
      if (state == IDLE) begin
        if (stall) begin
          state <= BUSY;
          cnt <= 4'(WAIT_CYCLES - 1);
        end
      end else if (cnt == 4'd0) state <= IDLE;
      else cnt <= cnt - 4'd1;
      bus.wb_control <= stall ? 2'b00 : bus.mem_wb;
      if (!stall) begin
        bus.wb_read_data <= rdata;
        bus.wb_alu_result <= bus.mem_address;
        bus.wb_write_reg <= wreg;
      end
    end
`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk)
    if (reset) bus.wb_misalign <= 1'b0;
    else if (!stall) bus.wb_misalign <= mis;
`endif
endmodule

// File: tb/tb_pipelined_mem_stage.sv
// tb_pipelined_mem_stage: drives a WAIT_CYCLES=0 and a WAIT_CYCLES=3 instance with identical stimulus against per-instance memory models
module tb_pipelined_mem_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  logic [1:0] wbc, sz;
  logic br, zr, wr, rd, uns;
  logic [31:0] addr, wd;
  logic [4:0] wreg;
  int checks = 0, errors = 0;
  logic [31:0] m0 [256];
  logic [31:0] m3 [256];
  pipelined_mem_stage_if #(.REG_W(5)) b0 ();
  pipelined_mem_stage_if #(.REG_W(5)) b3 ();
  assign b0.mem_wb = wbc;
  assign b0.mem_branch = br;
  assign b0.mem_zero = zr;
  assign b0.mem_address = addr;
  assign b0.mem_write_data = wd;
  assign b0.mem_write = wr;
  assign b0.mem_read = rd;
  assign b0.mem_size = sz;
  assign b0.mem_unsigned = uns;
  assign b0.write_reg = wreg;
  assign b3.mem_wb = wbc;
  assign b3.mem_branch = br;
  assign b3.mem_zero = zr;
  assign b3.mem_address = addr;
  assign b3.mem_write_data = wd;
  assign b3.mem_write = wr;
  assign b3.mem_read = rd;
  assign b3.mem_size = sz;
  assign b3.mem_unsigned = uns;
  assign b3.write_reg = wreg;
  pipelined_mem_stage #(.DEPTH(256), .WAIT_CYCLES(0), .REG_W(5)) u0 (.clk(clk), .reset(reset), .bus(b0));
  pipelined_mem_stage #(.DEPTH(256), .WAIT_CYCLES(3), .REG_W(5)) u3 (.clk(clk), .reset(reset), .bus(b3));

  function automatic logic [31:0] ld(input logic [31:0] w, input logic [1:0] s, input logic u, input logic [31:0] a);
    logic [31:0] v;
    if (s[1]) return w;
    if (s == 2'b01) begin
      v = (w >> (a[1] * 16)) & 32'hFFFF;
      if (!u && v[15]) v = v | 32'hFFFF0000;
    end else begin
      v = (w >> (a[1:0] * 8)) & 32'hFF;
      if (!u && v[7]) v = v | 32'hFFFFFF00;
    end
    return v;
  endfunction

  function automatic logic [31:0] st(input logic [31:0] w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] mk;
    int sh;
    if (s[1]) return d;
    sh = (s == 2'b01) ? a[1] * 16 : a[1:0] * 8;
    mk = (s == 2'b01) ? 32'hFFFF << sh : 32'hFF << sh;
    return (w & ~mk) | ((d << sh) & mk);
  endfunction

  function automatic logic misal(input logic r, input logic w, input logic [1:0] s, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    return (r | w) && (s == 2'b01 ? a[0] : s[1] && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // One instruction: held until the 3-wait instance commits; the 0-wait one is checked after the first edge.
  task automatic op(input logic r, input logic w, input logic [1:0] s, input logic u, input logic [31:0] a,
                    input logic [31:0] d, input logic [1:0] c, input logic [4:0] g, input logic b, input logic z);
    logic m;
    logic [31:0] e0, e3;
    int k, es;
    rd = r; wr = w; sz = s; uns = u; addr = a; wd = d; wbc = c; wreg = g; br = b; zr = z;
    m = misal(r, w, s, a);
    e0 = (r && !w && !m) ? ld(m0[a[9:2]], s, u, a) : 32'd0;
    e3 = (r && !w && !m) ? ld(m3[a[9:2]], s, u, a) : 32'd0;
    es = ((r | w) && !m) ? 3 : 0;
    if (w && !m) begin
      m0[a[9:2]] = st(m0[a[9:2]], s, a, d);
      m3[a[9:2]] = st(m3[a[9:2]], s, a, d);
    end
    #1;
    checks += 3;
    if (b0.mem_pcsrc !== (b & z)) begin errors++; $display("FAIL pcsrc: got %b expected %b", b0.mem_pcsrc, b & z); end
    if (b0.mem_stall !== 1'b0) begin errors++; $display("FAIL stall_w0: got %b expected 0", b0.mem_stall); end
    if (b3.mem_stall !== (es != 0)) begin errors++; $display("FAIL stall_start: got %b expected %b", b3.mem_stall, es != 0); end
    @(posedge clk); #1;
    k = 1;
    checks += 4;
    if (b0.wb_control !== c) begin errors++; $display("FAIL w0_ctrl: got %h expected %h", b0.wb_control, c); end
    if (b0.wb_read_data !== e0) begin errors++; $display("FAIL w0_rdata @%h: got %h expected %h", a, b0.wb_read_data, e0); end
    if (b0.wb_alu_result !== a) begin errors++; $display("FAIL w0_alu: got %h expected %h", b0.wb_alu_result, a); end
    if (b0.wb_write_reg !== g) begin errors++; $display("FAIL w0_reg: got %h expected %h", b0.wb_write_reg, g); end
`ifdef MEM_MISALIGN_TRAP_EN
    checks++;
    if (b0.wb_misalign !== m) begin errors++; $display("FAIL w0_misalign: got %b expected %b", b0.wb_misalign, m); end
`endif
    if (es != 0) begin
      checks++;
      if (b3.wb_control !== 2'b00) begin errors++; $display("FAIL bubble: got %h expected 0", b3.wb_control); end
    end
    while (b3.mem_stall && k < 20) begin
      @(posedge clk); #1;
      k++;
      checks++;
      if (b3.wb_control !== 2'b00) begin errors++; $display("FAIL bubble: got %h expected 0", b3.wb_control); end
    end
    if (es != 0) begin @(posedge clk); #1; k++; end
    checks += 5;
    if (k - 1 != es) begin errors++; $display("FAIL stall_len: got %0d expected %0d", k - 1, es); end
    if (b3.wb_control !== c) begin errors++; $display("FAIL w3_ctrl: got %h expected %h", b3.wb_control, c); end
    if (b3.wb_read_data !== e3) begin errors++; $display("FAIL w3_rdata @%h: got %h expected %h", a, b3.wb_read_data, e3); end
    if (b3.wb_alu_result !== a) begin errors++; $display("FAIL w3_alu: got %h expected %h", b3.wb_alu_result, a); end
    if (b3.wb_write_reg !== g) begin errors++; $display("FAIL w3_reg: got %h expected %h", b3.wb_write_reg, g); end
`ifdef MEM_MISALIGN_TRAP_EN
    checks++;
    if (b3.wb_misalign !== m) begin errors++; $display("FAIL w3_misalign: got %b expected %b", b3.wb_misalign, m); end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; rd = 0; wr = 0; sz = 0; uns = 0; addr = 0; wd = 0; wbc = 0; wreg = 0; br = 0; zr = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks += 6;
    if (b3.mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", b3.mem_stall); end
    if (b3.wb_control !== 2'b00) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", b3.wb_control); end
    if (b3.wb_read_data !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", b3.wb_read_data); end
    if (b3.wb_alu_result !== 32'd0) begin errors++; $display("FAIL reset_alu: got %h expected 0", b3.wb_alu_result); end
    if (b3.wb_write_reg !== 5'd0) begin errors++; $display("FAIL reset_reg: got %h expected 0", b3.wb_write_reg); end
    if (b0.wb_read_data !== 32'd0) begin errors++; $display("FAIL reset_rdata_w0: got %h expected 0", b0.wb_read_data); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 256; i++)
      op(1'b0, 1'b1, 2'b10, 1'b0, i * 4, $urandom, 2'($urandom), 5'($urandom), 1'b0, 1'b0);
  endtask

  task automatic test_aligned();
    op(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2'b01, 5'd3, 1'b0, 1'b0);
    op(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2'b11, 5'd4, 1'b0, 1'b0);
    checks++;
    if (b3.wb_read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL aligned_word: got %h expected deadbeef", b3.wb_read_data); end
  endtask

  task automatic test_byte_half();
    op(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 2'b00, 5'd0, 1'b0, 1'b0);
    op(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h00000080, 2'b00, 5'd0, 1'b0, 1'b0);
    op(1'b1, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 2'b11, 5'd7, 1'b0, 1'b0);
    checks++;
    if (b0.wb_read_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed: got %h expected ffffff80", b0.wb_read_data); end
    op(1'b1, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 2'b11, 5'd7, 1'b0, 1'b0);
    checks++;
    if (b0.wb_read_data !== 32'h00000080) begin errors++; $display("FAIL lb_unsigned: got %h expected 00000080", b0.wb_read_data); end
    op(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 2'b11, 5'd8, 1'b0, 1'b0);
    checks++;
    if (b3.wb_read_data !== 32'h11228044) begin errors++; $display("FAIL byte_lanes: got %h expected 11228044", b3.wb_read_data); end
    op(1'b1, 1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 2'b10, 5'd9, 1'b0, 1'b0);
    checks++;
    if (b3.wb_read_data !== 32'hFFFF8044) begin errors++; $display("FAIL lh_signed: got %h expected ffff8044", b3.wb_read_data); end
    op(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000ABCD, 2'b00, 5'd0, 1'b0, 1'b0);
    op(1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 2'b10, 5'd9, 1'b0, 1'b0);
  endtask

  task automatic test_wrap_priority();
    op(1'b0, 1'b1, 2'b10, 1'b0, 32'h400, 32'hA5A55A5A, 2'b01, 5'd1, 1'b0, 1'b0);
    op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 2'b01, 5'd2, 1'b0, 1'b0);
    checks++;
    if (b3.wb_read_data !== 32'hA5A55A5A) begin errors++; $display("FAIL wrap: got %h expected a5a55a5a", b3.wb_read_data); end
    op(1'b1, 1'b1, 2'b10, 1'b0, 32'h8, 32'h13572468, 2'b11, 5'd5, 1'b0, 1'b0);
    checks++;
    if (b0.wb_read_data !== 32'd0) begin errors++; $display("FAIL rw_rdata: got %h expected 0", b0.wb_read_data); end
    op(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 2'b11, 5'd5, 1'b0, 1'b0);
  endtask

  task automatic test_misalign();
    op(1'b0, 1'b1, 2'b10, 1'b0, 32'h13, 32'hCAFEF00D, 2'b01, 5'd6, 1'b0, 1'b0);
    op(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2'b01, 5'd6, 1'b0, 1'b0);
    op(1'b1, 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 2'b01, 5'd6, 1'b0, 1'b0);
    op(1'b0, 1'b1, 2'b01, 1'b0, 32'h31, 32'h0000BEEF, 2'b01, 5'd6, 1'b0, 1'b0);
    op(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 2'b01, 5'd6, 1'b0, 1'b0);
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 12; i++)
      op(1'b0, 1'b0, 2'($urandom), 1'($urandom), $urandom, $urandom, 2'($urandom), 5'($urandom), 1'(i), 1'(i >> 1));
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++)
      op(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
         2'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    d = ~m3[16];
    rd = 1'b0; wr = 1'b1; sz = 2'b10; addr = 32'h40; wd = d; wbc = 2'b01; wreg = 5'd9;
    m0[16] = d;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; wr = 1'b0;
    #1;
    checks += 5;
    if (b3.mem_stall !== 1'b0) begin errors++; $display("FAIL midreset_stall: got %b expected 0", b3.mem_stall); end
    if (b3.wb_control !== 2'b00) begin errors++; $display("FAIL midreset_ctrl: got %h expected 0", b3.wb_control); end
    if (b3.wb_read_data !== 32'd0) begin errors++; $display("FAIL midreset_rdata: got %h expected 0", b3.wb_read_data); end
    if (b3.wb_alu_result !== 32'd0) begin errors++; $display("FAIL midreset_alu: got %h expected 0", b3.wb_alu_result); end
    if (b3.wb_write_reg !== 5'd0) begin errors++; $display("FAIL midreset_reg: got %h expected 0", b3.wb_write_reg); end
    op(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 2'b10, 5'd9, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_aligned();
    test_byte_half();
    test_wrap_priority();
    test_misalign();
    test_passthrough();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipelined_mem_stage.md
PIPELINED_MEM_STAGE -- requirements
Module: pipelined_mem_stage

Interface
REQ-001 Parameters SHALL be as follows, one per line (name, default, meaning).
- DEPTH, 256, data memory words; power of two, 4..65536.
- WAIT_CYCLES, 0, memory access latency in stall cycles, 0..15.
- REG_W, 5, destination register index width.

REQ-002 Ports SHALL be as follows, one per line (name, direction, width, meaning).
- clk, in, 1, single clock; all state updates on rising edge.
- reset, in, 1, synchronous, active-high.
- mem_wb, in, 2, WB control bits carried to WB stage.
- mem_branch, in, 1, branch instruction flag.
- mem_zero, in, 1, ALU zero flag.
- mem_address, in, 32, ALU result / byte address.
- mem_write_data, in, 32, store data (low-aligned).
- mem_write, in, 1, store request.
- mem_read, in, 1, load request.
- mem_size, in, 2, access size: 00 byte, 01 half, 10 word, 11 treated as word.
- mem_unsigned, in, 1, load zero-extends when 1, sign-extends when 0.
- write_reg, in, REG_W, destination register.
- mem_pcsrc, out, 1, branch taken.
- mem_stall, out, 1, upstream hold request.
- wb_control, out, 2, registered WB control.
- wb_read_data, out, 32, registered extended load data.
- wb_alu_result, out, 32, registered mem_address.
- wb_write_reg, out, REG_W, registered destination.
- wb_misalign, out, 1, registered misalignment flag; present only with MEM_MISALIGN_TRAP_EN.

Function
REQ-003 mem_pcsrc SHALL equal mem_branch AND mem_zero, combinationally, independent of mem_stall.
REQ-004 The word index SHALL be mem_address[log2(DEPTH)+1:2]; higher address bits SHALL be ignored, so accesses wrap modulo DEPTH words.
REQ-005 A store SHALL update only the addressed byte lanes of the word:
- byte: lane = addr[1:0], data = write_data[7:0].
- half: lanes addr[1]*2 and addr[1]*2+1, data = write_data[15:0].
- word: all four lanes.
REQ-006 A load SHALL select the same lanes as REQ-005 and extend the result to 32 bits per mem_unsigned.
REQ-007 If mem_read and mem_write are both 1, the access SHALL be performed as a store only, and wb_read_data SHALL be captured as 0.
REQ-008 A request SHALL be mem_read OR mem_write. The FSM SHALL have states IDLE and BUSY, with a wait counter cnt.
REQ-009 With WAIT_CYCLES=0, a request SHALL complete at the same edge it is presented, and mem_stall SHALL remain 0.
REQ-010 With WAIT_CYCLES=N>0, the wait sequence SHALL be:
- a request seen in IDLE drives mem_stall=1 combinationally, and the FSM enters BUSY with cnt=N-1;
- in BUSY, mem_stall=1 while cnt>0, and cnt decrements each cycle;
- when cnt=0, mem_stall=0, the access commits at that edge, and the FSM returns to IDLE.
Net effect: mem_stall is high for exactly N cycles, and the access completes N cycles after first presentation.
REQ-011 Upstream SHALL hold all inputs stable while mem_stall=1. The memory array SHALL NOT be written before the commit edge.
REQ-012 At every edge where mem_stall=0, the MEM/WB register SHALL load mem_wb, the load data, mem_address and write_reg. Non-memory instructions SHALL pass through in one cycle with no stall.
REQ-013 At every edge where mem_stall=1, the MEM/WB register SHALL load a bubble (wb_control=00) and hold its other fields.
REQ-014 Load data for a store or a non-memory instruction SHALL be captured as 0.

Reset
REQ-015 When reset=1 at an edge, the block SHALL set:
- FSM to IDLE, cnt=0;
- wb_control=0, wb_read_data=0, wb_alu_result=0, wb_write_reg=0, and wb_misalign=0 when present.
REQ-016 mem_stall SHALL be 0 in the cycle following reset. A reset during BUSY SHALL abandon the access with no memory write.
REQ-017 Memory array contents SHALL NOT be cleared by reset.

Configuration
REQ-018 Misalignment trapping SHALL be controlled by macro MEM_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, is misaligned. It SHALL perform no write and no wait (no stall), capture wb_read_data=0, and register wb_misalign=1 for that instruction. The wb_misalign port exists.
- Undefined: no wb_misalign port. Misaligned low address bits SHALL be forced to 0 (half ignores addr[0], word ignores addr[1:0]).

Verification
REQ-019 Aligned access, WAIT_CYCLES=0: store word 0xDEADBEEF at 0x10, then load word at 0x10 -> wb_read_data=0xDEADBEEF one cycle later, and mem_stall stays 0.
REQ-020 Byte and half extension: store byte 0x80 at 0x21; a signed load byte -> 0xFFFFFF80; an unsigned load byte -> 0x00000080; the other lanes of word 8 are unchanged.
REQ-021 Wait states, WAIT_CYCLES=3: a load request -> mem_stall high for exactly 3 cycles; wb_control=00 during the stall; data valid in MEM/WB on the 4th edge.
REQ-022 Reset mid-operation, WAIT_CYCLES=3: assert reset in the 2nd stall cycle of a store -> memory is unchanged, FSM is IDLE, all wb_* outputs are 0.
REQ-023 Wrap-around and priority, DEPTH=256: a store to 0x400 aliases word 0; mem_read and mem_write both 1 -> a store is performed and wb_read_data=0.
REQ-024 With MEM_MISALIGN_TRAP_EN defined: a store word at 0x13 -> no write, no stall, wb_misalign=1; a following aligned load -> wb_misalign=0.
